// File: rtl/cell_dequeue_scheduler_pkg.sv
// Shared widths, FSM encoding and helpers for the cell dequeue scheduler.
package cell_dequeue_scheduler_pkg;

    localparam int PTR_W  = 10;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 128;
    localparam int NPORT  = 4;
    localparam int BEATS  = 4;
    localparam int PORT_W = 2;
    localparam int BEAT_W = 2;

    localparam logic [BEAT_W-1:0] LAST_BEAT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_READ    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    function automatic logic [NPORT-1:0] port_onehot(input logic [PORT_W-1:0] port);
        port_onehot = 4'b0001 << port;
    endfunction

endpackage

// File: rtl/cell_dequeue_scheduler_rr_arbiter.sv
// Four-way round-robin selector: combinational grant searching from last_grant+1,
// with last_grant registered whenever the grant is taken.
module rr_arbiter_4
    import cell_dequeue_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic [NPORT-1:0]  req,
    input  logic              en,
    output logic [PORT_W-1:0] grant,
    output logic              grant_valid
);

    logic [PORT_W-1:0] last_grant_r;
    logic [PORT_W-1:0] grant_s;
    logic [PORT_W-1:0] cand_s;
    logic              grant_valid_s;

    // Search farthest-first so the nearest requester after last_grant wins.
    always_comb begin
        grant_s       = last_grant_r;
        grant_valid_s = 1'b0;
        cand_s        = last_grant_r;
        for (int i = NPORT; i >= 1; i--) begin
            cand_s        = last_grant_r + PORT_W'(i);
            grant_s       = req[cand_s] ? cand_s : grant_s;
            grant_valid_s = grant_valid_s | req[cand_s];
        end
    end

    // Remember the winner only when the grant is actually consumed.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_grant_r <= 2'd3;
        end else if (en && grant_valid_s) begin
            last_grant_r <= grant_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign grant       = grant_s;
    assign grant_valid = grant_valid_s;

endmodule

// File: rtl/cell_dequeue_scheduler.sv
// Egress cell scheduler: picks a port round-robin, pops its head pointer,
// streams the four cell beats from SRAM, then returns the pointer to the free queue.
module cell_dequeue_scheduler
    import cell_dequeue_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic [NPORT-1:0]  q_nonempty,
    input  logic [NPORT-1:0]  port_bp,
    output logic              deq_req,
    output logic [PORT_W-1:0] deq_port,
    input  logic              deq_ack,
    input  logic [PTR_W-1:0]  deq_ptr,
    output logic              sram_rd,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_dout,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_wr,
    output logic [NPORT-1:0]  o_port,
    output logic              FQ_wr,
    output logic [PTR_W-1:0]  FQ_din
);

    state_t            state_r;
    logic [PORT_W-1:0] grant_r;
    logic [PTR_W-1:0]  ptr_r;
    logic [BEAT_W-1:0] beat_r;

    logic              deq_req_r;
    logic [PORT_W-1:0] deq_port_r;
    logic              sram_rd_r;
    logic [ADDR_W-1:0] sram_addr_r;
    logic              o_data_wr_r;
    logic [NPORT-1:0]  o_port_r;
    logic              fq_wr_r;
    logic [PTR_W-1:0]  fq_din_r;

    logic [NPORT-1:0]  eligible_s;
    logic [PORT_W-1:0] arb_grant_s;
    logic              arb_valid_s;
    logic              arb_en_s;

    assign eligible_s = q_nonempty & ~port_bp;
    assign arb_en_s   = (state_r == ST_IDLE);

    rr_arbiter_4 u_arb (
        .clk         (clk),
        .rstn        (rstn),
        .req         (eligible_s),
        .en          (arb_en_s),
        .grant       (arb_grant_s),
        .grant_valid (arb_valid_s)
    );

    // Transfer FSM; every output is a register so reset clears them in one edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            grant_r     <= 2'd0;
            ptr_r       <= 10'd0;
            beat_r      <= 2'd0;
            deq_req_r   <= 1'b0;
            deq_port_r  <= 2'd0;
            sram_rd_r   <= 1'b0;
            sram_addr_r <= 12'd0;
            o_data_wr_r <= 1'b0;
            o_port_r    <= 4'd0;
            fq_wr_r     <= 1'b0;
            fq_din_r    <= 10'd0;
        end else begin
            // SRAM data lands one cycle after the strobe, so egress trails sram_rd.
            o_data_wr_r <= sram_rd_r;
            o_port_r    <= sram_rd_r ? port_onehot(grant_r) : 4'd0;
            case (state_r)
                ST_IDLE: begin
                    if (arb_valid_s) begin
                        grant_r    <= arb_grant_s;
                        deq_req_r  <= 1'b1;
                        deq_port_r <= arb_grant_s;
                        state_r    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (deq_ack) begin
                        ptr_r       <= deq_ptr;
                        deq_req_r   <= 1'b0;
                        deq_port_r  <= 2'd0;
                        sram_rd_r   <= 1'b1;
                        beat_r      <= 2'd0;
                        sram_addr_r <= {deq_ptr, 2'd0};
                        state_r     <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (beat_r == LAST_BEAT) begin
                        sram_rd_r   <= 1'b0;
                        sram_addr_r <= 12'd0;
                        beat_r      <= 2'd0;
                        state_r     <= ST_DRAIN;
                    end else begin
                        beat_r      <= beat_r + 2'd1;
                        sram_addr_r <= {ptr_r, beat_r + 2'd1};
                    end
                end
                ST_DRAIN: begin
                    fq_wr_r  <= 1'b1;
                    fq_din_r <= ptr_r;
                    state_r  <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    fq_wr_r  <= 1'b0;
                    fq_din_r <= 10'd0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    deq_req_r   <= 1'b0;
                    sram_rd_r   <= 1'b0;
                    sram_addr_r <= 12'd0;
                    fq_wr_r     <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign deq_req   = deq_req_r;
    assign deq_port  = deq_port_r;
    assign sram_rd   = sram_rd_r;
    assign sram_addr = sram_addr_r;
    assign o_data_wr = o_data_wr_r;
    assign o_data    = o_data_wr_r ? sram_dout : {DATA_W{1'b0}};
    assign o_port    = o_port_r;
    assign FQ_wr     = fq_wr_r;
    assign FQ_din    = fq_din_r;

endmodule

// File: tb/tb_cell_dequeue_scheduler.sv
// Self-checking bench for cell_dequeue_scheduler: directed vector table, reset
// corner case, and randomized cells checked against a round-robin reference model.
module tb_cell_dequeue_scheduler;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   q_nonempty;
    logic [3:0]   port_bp;
    logic         deq_req;
    logic [1:0]   deq_port;
    logic         deq_ack;
    logic [9:0]   deq_ptr;
    logic         sram_rd;
    logic [11:0]  sram_addr;
    logic [127:0] sram_dout = 128'd0;
    logic [127:0] o_data;
    logic         o_data_wr;
    logic [3:0]   o_port;
    logic         FQ_wr;
    logic [9:0]   FQ_din;

    int n_cmp = 0;
    int n_err = 0;
    int last_m = 3;

    cell_dequeue_scheduler dut (
        .clk        (clk),
        .rstn       (rstn),
        .q_nonempty (q_nonempty),
        .port_bp    (port_bp),
        .deq_req    (deq_req),
        .deq_port   (deq_port),
        .deq_ack    (deq_ack),
        .deq_ptr    (deq_ptr),
        .sram_rd    (sram_rd),
        .sram_addr  (sram_addr),
        .sram_dout  (sram_dout),
        .o_data     (o_data),
        .o_data_wr  (o_data_wr),
        .o_port     (o_port),
        .FQ_wr      (FQ_wr),
        .FQ_din     (FQ_din)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] beat_data(input logic [11:0] a);
        return {8{a, 4'h5}};
    endfunction

    // SRAM model: data for the strobed address appears one cycle later, junk otherwise.
    always @(posedge clk) sram_dout <= sram_rd ? beat_data(sram_addr) : {4{32'hDEADBEEF}};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [3:0] q, input logic [3:0] bp, input int last);
        for (int i = 1; i <= 4; i++) begin
            int p;
            p = (last + i) % 4;
            if (q[p] && !bp[p]) return p;
        end
        return -1;
    endfunction

    task automatic check_idle(input string name);
        chk(name, {deq_req, deq_port, sram_rd, sram_addr, o_data_wr, o_port, FQ_wr, FQ_din}, 128'd0);
        chk({name, "_odata"}, o_data, 128'd0);
    endtask

    task automatic wait_req(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!deq_req && cycles < 40);
        chk("req_timeout", {127'd0, deq_req}, 128'd1);
    endtask

    // One complete cell: grant, optional ack delay, 4 reads, 4 egress beats, free.
    task automatic run_cell(input int exp_port, input logic [9:0] ptr, input int delay,
                            input logic [3:0] bp_mid);
        int w;
        logic [1:0] pexp;
        pexp = 2'(exp_port);
        wait_req(w);
        chk("grant_latency", 128'(w), 128'd1);
        chk("grant_port", {126'd0, deq_port}, {126'd0, pexp});
        for (int d = 0; d < delay; d++) begin
            chk("req_hold", {125'd0, deq_req, deq_port, sram_rd}, {125'd0, 1'b1, pexp, 1'b0});
            @(negedge clk);
        end
        deq_ack = 1'b1;
        deq_ptr = ptr;
        @(negedge clk);
        deq_ack = 1'b0;
        deq_ptr = 10'($urandom);
        for (int k = 1; k <= 6; k++) begin
            logic exp_rd, exp_wr;
            exp_rd = (k <= 4);
            exp_wr = (k >= 2 && k <= 5);
            chk("sram_rd", {127'd0, sram_rd}, {127'd0, exp_rd});
            if (exp_rd) chk("sram_addr", {116'd0, sram_addr}, {116'd0, ptr, 2'(k - 1)});
            chk("o_data_wr", {127'd0, o_data_wr}, {127'd0, exp_wr});
            chk("o_port", {124'd0, o_port}, exp_wr ? 128'(4'b0001 << pexp) : 128'd0);
            if (exp_wr) chk("o_data", o_data, beat_data({ptr, 2'(k - 2)}));
            chk("fq_wr", {127'd0, FQ_wr}, {127'd0, (k == 6)});
            if (k == 6) chk("fq_din", {118'd0, FQ_din}, {118'd0, ptr});
            chk("req_low", {127'd0, deq_req}, 128'd0);
            if (k == 2) port_bp = bp_mid;
            if (k == 3) begin
                deq_ack = 1'b1;
                deq_ptr = ~ptr;
            end
            if (k == 4) begin
                deq_ack = 1'b0;
                q_nonempty = 4'b0000;
            end
            @(negedge clk);
        end
        last_m = exp_port;
    endtask

    typedef struct {
        logic [3:0] q;
        logic [3:0] bp;
        logic [3:0] bp_mid;
        logic [9:0] ptr;
        int         delay;
        int         exp_port;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp;
        tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 10'h010, 2,  0};
        tbl[1]  = '{4'b1111, 4'b0000, 4'b0000, 10'h3FF, 0,  1};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0000, 10'h000, 0,  2};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b0000, 10'h155, 0,  3};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0000, 10'h2AA, 0,  0};
        tbl[5]  = '{4'b1111, 4'b0000, 4'b0000, 10'h001, 1,  1};
        tbl[6]  = '{4'b1111, 4'b0000, 4'b0000, 10'h3FE, 0,  2};
        tbl[7]  = '{4'b1111, 4'b0000, 4'b0000, 10'h080, 0,  3};
        tbl[8]  = '{4'b1111, 4'b0000, 4'b0000, 10'h100, 0,  0};
        tbl[9]  = '{4'b0101, 4'b0001, 4'b0100, 10'h0F0, 0,  2};
        tbl[10] = '{4'b0101, 4'b0001, 4'b0000, 10'h00F, 0,  2};
        tbl[11] = '{4'b1000, 4'b0000, 4'b0000, 10'h222, 20, 3};
        tbl[12] = '{4'b0110, 4'b0100, 4'b0000, 10'h333, 0,  1};

        rstn = 1'b0;
        q_nonempty = 4'b1111;
        port_bp = 4'b0000;
        deq_ack = 1'b0;
        deq_ptr = 10'd0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rstn = 1'b1;
        q_nonempty = 4'b0000;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            q_nonempty = tbl[i].q;
            port_bp = tbl[i].bp;
            run_cell(tbl[i].exp_port, tbl[i].ptr, tbl[i].delay, tbl[i].bp_mid);
        end

        // Nothing eligible: outputs stay idle and a stray ack is ignored.
        q_nonempty = 4'b1111;
        port_bp = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            deq_ack = (c == 2);
            @(negedge clk);
            check_idle("idle_hold");
        end
        deq_ack = 1'b0;

        // Reset while beat 1 is on the SRAM bus.
        q_nonempty = 4'b0010;
        port_bp = 4'b0000;
        exp = model_grant(q_nonempty, port_bp, last_m);
        begin
            int w;
            wait_req(w);
        end
        chk("rst_grant", {126'd0, deq_port}, 128'(exp));
        deq_ack = 1'b1;
        deq_ptr = 10'h155;
        @(negedge clk);
        deq_ack = 1'b0;
        @(negedge clk);
        chk("rst_beat1", {116'd0, sram_addr}, {116'd0, 10'h155, 2'd1});
        rstn = 1'b0;
        q_nonempty = 4'b0000;
        @(negedge clk);
        check_idle("rst_mid");
        rstn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rst_quiet", {125'd0, FQ_wr, sram_rd, o_data_wr}, 128'd0);
        end
        last_m = 3;
        q_nonempty = 4'b1111;
        run_cell(model_grant(q_nonempty, port_bp, last_m), 10'h3FF, 0, 4'b0000);

        // Randomized cells against the round-robin reference model.
        for (int r = 0; r < 30; r++) begin
            q_nonempty = 4'($urandom);
            port_bp = 4'($urandom & $urandom);
            exp = model_grant(q_nonempty, port_bp, last_m);
            if (exp < 0) begin
                repeat (3) begin
                    @(negedge clk);
                    check_idle("rand_idle");
                end
            end else begin
                run_cell(exp, 10'($urandom), int'($urandom_range(0, 3)), 4'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cell_dequeue_scheduler.md
CELL_DEQUEUE_SCHEDULER -- requirements
Module: cell_dequeue_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and rstn.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rstn  in  1  synchronous active-low reset.
REQ-004 q_nonempty  in  4  per-output-port flag; high means the port queue holds at least one cell.
REQ-005 port_bp  in  4  per-port backpressure; high excludes that port from arbitration.
REQ-006 deq_req  out  1  request for the head cell pointer of deq_port.
REQ-007 deq_port  out  2  port index being dequeued.
REQ-008 deq_ack  in  1  one-cycle pulse; deq_ptr is valid in the same cycle.
REQ-009 deq_ptr  in  10  cell pointer popped from the port queue.
REQ-010 sram_rd  out  1  cell-SRAM read strobe.
REQ-011 sram_addr  out  12  read address, {ptr[9:0], beat[1:0]}.
REQ-012 sram_dout  in  128  read data, valid exactly one cycle after sram_rd.
REQ-013 o_data  out  128  egress beat.
REQ-014 o_data_wr  out  1  egress beat valid.
REQ-015 o_port  out  4  one-hot egress port, held stable for all 4 beats.
REQ-016 FQ_wr  out  1  one-cycle pulse returning a pointer to the free queue.
REQ-017 FQ_din  out  10  pointer being freed.

Function
REQ-018 FSM states SHALL be IDLE, REQ, READ, DRAIN and RELEASE.
REQ-019 IDLE: eligible = q_nonempty & ~port_bp; if eligible is nonzero, the block SHALL grant by round-robin and move to REQ next cycle, otherwise stay in IDLE.
REQ-020 Round-robin search SHALL start at last_grant+1 mod 4, and last_grant SHALL update only on a grant.
REQ-021 REQ: deq_req SHALL be high with deq_port equal to the granted port until the cycle deq_ack is sampled high; in that cycle deq_ptr SHALL be latched and the FSM SHALL move to READ.
REQ-022 deq_ack sampled outside the REQ state SHALL be ignored.
REQ-023 READ: sram_rd SHALL be high for exactly 4 consecutive cycles, with beat incrementing 0,1,2,3 in sram_addr[1:0] and sram_addr[11:2] equal to the latched pointer.
REQ-024 The first sram_rd SHALL occur in the cycle after deq_ack.
REQ-025 After beat 3 the FSM SHALL move to DRAIN.
REQ-026 o_data_wr SHALL equal sram_rd delayed by one cycle, and o_data SHALL equal sram_dout in that cycle; o_port SHALL be the one-hot granted port while o_data_wr is high and 0 otherwise.
REQ-027 DRAIN lasts one cycle, covering the last data beat, then the FSM SHALL move to RELEASE.
REQ-028 RELEASE: FQ_wr SHALL be pulsed for one cycle with FQ_din equal to the latched pointer, then the FSM SHALL return to IDLE.
REQ-029 Latency from deq_ack to the first o_data_wr SHALL be 2 cycles, and to FQ_wr 6 cycles.
REQ-030 Minimum cell period SHALL be 8 cycles (IDLE, REQ, 4 READ, DRAIN, RELEASE).
REQ-031 A cell transfer SHALL be atomic: port_bp or q_nonempty changes after grant SHALL NOT stall or abort it.
REQ-032 With all eligible bits zero, all outputs SHALL hold their idle values.
REQ-033 Pointer values 0 and 1023 SHALL be handled identically to other values, with no wrap of sram_addr beyond a beat index of 3.

Reset
REQ-034 While rstn=0 at a clock edge: FSM=IDLE, last_grant=3 (so the first search starts at port 0), beat=0, and latched pointer=0.
REQ-035 While rstn=0 at a clock edge: deq_req, sram_rd, o_data_wr, FQ_wr, o_port, deq_port, sram_addr and FQ_din SHALL all be 0; o_data SHALL be 0.
REQ-036 Reset mid-transfer SHALL abort immediately with no further beats and no FQ_wr; pointer recovery is the responsibility of the system reset of the queue memories.

Structure
REQ-037 A shared package SHALL hold PTR_W=10, ADDR_W=12, DATA_W=128, NPORT=4, BEATS=4 and the FSM state encoding.
REQ-038 The round-robin selector SHALL be the sub-module rr_arbiter_4: combinational grant from a 4-bit request and last_grant, with registered last_grant update on an enable.

Verification
REQ-039 Single cell: q_nonempty=0001, deq_ack with deq_ptr=0x010 two cycles after deq_req -> sram_addr 0x040..0x043, 4 beats on o_port=0001, FQ_wr with FQ_din=0x010 6 cycles after ack.
REQ-040 Fairness: q_nonempty=1111 held for 8 cells -> grant order 0,1,2,3,0,1,2,3 and o_port cycling 0001, 0010, 0100, 1000.
REQ-041 Backpressure: q_nonempty=0101, port_bp=0001 -> only port 2 is served; port_bp raised mid-transfer still completes 4 beats.
REQ-042 Delayed ack: deq_ack withheld for 20 cycles -> deq_req and deq_port stay stable, with no sram_rd until the ack.
REQ-043 Reset during READ beat 1 -> next cycle all outputs are 0, no FQ_wr, and the following grant goes to port 0.
REQ-044 Pointer boundary: deq_ptr=0x3FF -> sram_addr 0xFFC..0xFFF and FQ_din=0x3FF.
